cmul_arbiter: RTL and testbench
===============================

// Module: cmul_arbiter
// PURPOSE
//  Shares one pipelined complex multiplier (4 FP mults + FP add/sub, fixed latency, no stall) among
//  NREQ gridding requesters. Round-robin issue of one operand set per cycle, each tagged with its
//  requester ID. Results are returned in issue order through an output FIFO. Credit-based issue
//  guarantees FIFO cannot overflow under output backpressure. Sits between gridding lanes and the datapath.
// PARAMETERS
//  PRECISION   32  float word width (IEEE single)
//  NREQ         4  number of requesters (>=2); TAGW = clog2(NREQ), localparam
//  LATENCY     14  cycles from mul_a*/mul_b* change to matching mul_c* (datapath mult+add latency)
//  FIFO_DEPTH  32  result FIFO entries, power of 2; must be >= LATENCY+2 for full throughput
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous, active-low reset
//  req_valid  in   NREQ            requester i has an operand set
//  req_ready  out  NREQ            one-hot grant; transfer when req_valid[i]&req_ready[i]
//  req_areal  in   NREQ*PRECISION  a real, lane i at [i*PRECISION +: PRECISION]; same for aimag/breal/bimag
//  req_aimag  in   NREQ*PRECISION  a imag
//  req_breal  in   NREQ*PRECISION  b real
//  req_bimag  in   NREQ*PRECISION  b imag
//  mul_areal/mul_aimag/mul_breal/mul_bimag  out  PRECISION each  registered operands to datapath
//  mul_creal  in   PRECISION       datapath result real
//  mul_cimag  in   PRECISION       datapath result imag
//  res_valid  out  1               FIFO head valid
//  res_ready  in   1               consumer accepts head
//  res_real   out  PRECISION       result real
//  res_imag   out  PRECISION       result imag
//  res_tag    out  TAGW            requester index of result
// BEHAVIOUR
//  Reset (rst low, async): req_ready=0, mul_*=0, res_valid=0, res_real/imag/tag=0, valid pipe
//   cleared, FIFO empty, RR pointer=NREQ-1 (req 0 has first priority). Datapath sclr tied to ~rst by integrator.
//  Credits: occ = fifo_count + inflight (valid bits in issue reg + LATENCY-stage tag pipe).
//   Grant allowed in cycle only if occ < FIFO_DEPTH, or occ == FIFO_DEPTH-? never: strict <.
//  Arbitration (combinational, same cycle): if allowed, req_ready = one-hot of first req_valid[i]
//   scanning ptr+1, ptr+2, ... mod NREQ; else req_ready=0. req_ready[i] never set without req_valid[i].
//   On transfer ptr<=granted i. No transfer -> ptr holds.
//  Issue: transfer in cycle T -> mul_* loaded at edge ending T (visible T+1), issue-valid/tag
//   registered alongside; valid/tag shifted LATENCY stages; at cycle T+1+LATENCY, mul_c* captured
//   into FIFO with tag; res_valid earliest at T+2+LATENCY. Idle cycles: mul_* hold, valid bit 0.
//  Throughput: 1 issue/cycle sustained while res_ready=1 and FIFO_DEPTH >= LATENCY+2.
//  FIFO: push/pop same cycle allowed incl. at full/empty boundaries (count unchanged); pop on
//   res_valid&res_ready; head data stable while res_valid&!res_ready. Order = issue order.
//  Overflow impossible by credit rule; push while full is a design error (sim assertion).
//  Reset mid-operation: in-flight and queued results discarded; no res_valid for pre-reset issues.
//  Arithmetic is entirely in the datapath; block never inspects float values.
// TESTING
//  1 Single req0 a=(1.0,2.0) b=(3.0,4.0) at T -> res (-5.0,10.0) tag 0, res_valid first at T+2+LATENCY.
//  2 All 4 valid continuously, res_ready=1 -> grants 0,1,2,3,0,... one per cycle; tags same order; no gaps.
//  3 res_ready=0 with all valid -> exactly FIFO_DEPTH accepts then req_ready=0; release -> no loss, order kept.
//  4 Only req2,req3 valid, ptr=2 -> grant 3 then 2 alternately; req0/1 never granted.
//  5 rst pulsed low with 5 in flight, 3 queued -> outputs 0 immediately; none of the 8 ever emerge.
//  6 Simultaneous push+pop at FIFO full, and at count 1 -> count unchanged, data integrity checked vs model.

Source files
------------

// File: rtl/cmul_arbiter_if.sv
// Bundle of requester, datapath and result signals around the shared complex multiplier.
// slave is the arbiter's view; master is the view of the lanes, datapath and consumer.
interface cmul_arbiter_if #(
   parameter int PRECISION = 32,
   parameter int NREQ      = 4
);
   localparam int TAGW = $clog2(NREQ);

   logic [NREQ-1:0]           req_valid;
   logic [NREQ-1:0]           req_ready;
   logic [NREQ*PRECISION-1:0] req_areal;
   logic [NREQ*PRECISION-1:0] req_aimag;
   logic [NREQ*PRECISION-1:0] req_breal;
   logic [NREQ*PRECISION-1:0] req_bimag;

   logic [PRECISION-1:0]      mul_areal;
   logic [PRECISION-1:0]      mul_aimag;
   logic [PRECISION-1:0]      mul_breal;
   logic [PRECISION-1:0]      mul_bimag;
   logic [PRECISION-1:0]      mul_creal;
   logic [PRECISION-1:0]      mul_cimag;

   logic                      res_valid;
   logic                      res_ready;
   logic [PRECISION-1:0]      res_real;
   logic [PRECISION-1:0]      res_imag;
   logic [TAGW-1:0]           res_tag;

   modport slave (
      input  req_valid, req_areal, req_aimag, req_breal, req_bimag,
      output req_ready,
      output mul_areal, mul_aimag, mul_breal, mul_bimag,
      input  mul_creal, mul_cimag,
      output res_valid, res_real, res_imag, res_tag,
      input  res_ready
   );

   modport master (
      output req_valid, req_areal, req_aimag, req_breal, req_bimag,
      input  req_ready,
      input  mul_areal, mul_aimag, mul_breal, mul_bimag,
      output mul_creal, mul_cimag,
      input  res_valid, res_real, res_imag, res_tag,
      output res_ready
   );
endinterface

// File: rtl/cmul_arbiter.sv
// Round-robin sharing of one fixed-latency complex multiplier among NREQ lanes, with results
// returned in issue order through a credit-protected FIFO. Float words are passed through untouched.
module cmul_arbiter #(
   parameter int PRECISION  = 32,
   parameter int NREQ       = 4,
   parameter int LATENCY    = 14,
   parameter int FIFO_DEPTH = 32
) (
   input  logic          clk,
   input  logic          rst,
   cmul_arbiter_if.slave bus
);
   localparam int TAGW = $clog2(NREQ);
   localparam int AW   = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic [TAGW-1:0]      tag;
      logic [PRECISION-1:0] re;
      logic [PRECISION-1:0] im;
   } res_t;

   logic [TAGW-1:0] ptr;
   logic [TAGW-1:0] gnt_idx;
   logic            gnt_any;
   logic [NREQ-1:0] gnt;
   int              scan_idx;
   int              inflight;
   int              occ;
   logic            allow;

   logic [LATENCY:0] vpipe;
   logic [TAGW-1:0]  tpipe [LATENCY+1];

   res_t            mem [FIFO_DEPTH];
   res_t            head;
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            push;
   logic            pop;
   logic            full;

   // Every issued set already owns a FIFO slot, so the FIFO can never be pushed past full.
   // NOTE: always_comb assigns every output a default first so no path can infer a latch.
   always_comb begin
      inflight = 0;
      for (int s = 0; s <= LATENCY; s++) inflight += int'(vpipe[s]);
      occ   = int'(count) + inflight;
      allow = rst && (occ < FIFO_DEPTH);
   end

   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      scan_idx = 0;
      if (allow) begin
         for (int k = 1; k <= NREQ; k++) begin
            scan_idx = (int'(ptr) + k) % NREQ;
            if (!gnt_any && bus.req_valid[scan_idx]) begin
               gnt_any = 1'b1;
               gnt_idx = TAGW'(scan_idx);
            end
         end
      end
      if (gnt_any) gnt[gnt_idx] = 1'b1;
   end

   assign bus.req_ready = gnt;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr           <= TAGW'(NREQ - 1);
         bus.mul_areal <= '0;
         bus.mul_aimag <= '0;
         bus.mul_breal <= '0;
         bus.mul_bimag <= '0;
         vpipe         <= '0;
         for (int s = 0; s <= LATENCY; s++) tpipe[s] <= '0;
      end else begin
         vpipe    <= {vpipe[LATENCY-1:0], gnt_any};
         tpipe[0] <= gnt_idx;
         for (int s = 1; s <= LATENCY; s++) tpipe[s] <= tpipe[s-1];
         if (gnt_any) begin
            ptr           <= gnt_idx;
            bus.mul_areal <= bus.req_areal[gnt_idx*PRECISION +: PRECISION];
            bus.mul_aimag <= bus.req_aimag[gnt_idx*PRECISION +: PRECISION];
            bus.mul_breal <= bus.req_breal[gnt_idx*PRECISION +: PRECISION];
            bus.mul_bimag <= bus.req_bimag[gnt_idx*PRECISION +: PRECISION];
         end
      end
   end

   assign push = vpipe[LATENCY];
   assign pop  = bus.res_valid && bus.res_ready;
   assign full = (count == (AW+1)'(FIFO_DEPTH));

   // NOTE: the storage array has no reset; validity lives entirely in count and the pointers.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{tag: tpipe[LATENCY], re: bus.mul_creal, im: bus.mul_cimag};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Head is masked to zero when empty so stale storage never shows on the result port.
   assign head          = mem[rd_ptr];
   assign bus.res_valid = (count != '0);
   assign bus.res_real  = bus.res_valid ? head.re  : '0;
   assign bus.res_imag  = bus.res_valid ? head.im  : '0;
   assign bus.res_tag   = bus.res_valid ? head.tag : '0;

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: tb/tb_cmul_arbiter.sv
// Randomized bench for cmul_arbiter: a transaction-level model predicts grants, credits and the
// ordered result stream; a behavioural multiplier pipeline stands in for the datapath.
module tb_cmul_arbiter;
   localparam int PREC  = 32;
   localparam int NREQ  = 4;
   localparam int LAT   = 14;
   localparam int DEPTH = 32;
   localparam int TAGW  = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cmul_arbiter_if #(.PRECISION(PREC), .NREQ(NREQ)) bus ();

   cmul_arbiter #(.PRECISION(PREC), .NREQ(NREQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic real f32_to_real(input logic [31:0] b);
      if (b[30:0] == 31'd0) return 0.0;
      return $bitstoreal({b[31], 11'(int'(b[30:23]) - 127 + 1023), b[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] real_to_f32(input real r);
      logic [63:0] d;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
   endfunction

   // Behavioural datapath: complex product appears LAT cycles after the operands change.
   logic [31:0] dp_re [LAT];
   logic [31:0] dp_im [LAT];
   always @(posedge clk) begin
      dp_re[0] <= real_to_f32(f32_to_real(bus.mul_areal) * f32_to_real(bus.mul_breal)
                            - f32_to_real(bus.mul_aimag) * f32_to_real(bus.mul_bimag));
      dp_im[0] <= real_to_f32(f32_to_real(bus.mul_areal) * f32_to_real(bus.mul_bimag)
                            + f32_to_real(bus.mul_aimag) * f32_to_real(bus.mul_breal));
      for (int s = 1; s < LAT; s++) begin
         dp_re[s] <= dp_re[s-1];
         dp_im[s] <= dp_im[s-1];
      end
   end
   assign bus.mul_creal = dp_re[LAT-1];
   assign bus.mul_cimag = dp_im[LAT-1];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   typedef struct {
      int           due;
      logic [127:0] r;
   } pend_t;

   pend_t        pend [$];
   logic [127:0] mq [$];
   int           m_ptr;
   int           cyc;
   int           dut_acc;
   logic [NREQ-1:0] vld;
   logic         rr;
   int           ar [NREQ];
   int           ai [NREQ];
   int           br [NREQ];
   int           bi [NREQ];

   function automatic int model_grant();
      if (pend.size() + mq.size() >= DEPTH) return -1;
      for (int k = 1; k <= NREQ; k++) begin
         if (vld[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic pack();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_areal[i*PREC +: PREC] = real_to_f32(real'(ar[i]));
         bus.req_aimag[i*PREC +: PREC] = real_to_f32(real'(ai[i]));
         bus.req_breal[i*PREC +: PREC] = real_to_f32(real'(br[i]));
         bus.req_bimag[i*PREC +: PREC] = real_to_f32(real'(bi[i]));
      end
   endtask

   task automatic drive(input logic [NREQ-1:0] mask, input int ready_pct);
      vld = mask;
      rr  = (int'($urandom_range(99)) < ready_pct);
      for (int i = 0; i < NREQ; i++) begin
         ar[i] = int'($urandom_range(16)) - 8;
         ai[i] = int'($urandom_range(16)) - 8;
         br[i] = int'($urandom_range(16)) - 8;
         bi[i] = int'($urandom_range(16)) - 8;
      end
      pack();
      bus.req_valid = vld;
      bus.res_ready = rr;
   endtask

   // One clock cycle: compare at the falling edge, then advance the model past the rising edge.
   task automatic tick();
      int           g;
      logic [127:0] e;
      @(negedge clk);
      while (pend.size() > 0 && pend[0].due <= cyc) mq.push_back(pend.pop_front().r);
      g = model_grant();
      check("grant", 128'(bus.req_ready), (g >= 0) ? 128'(1) << g : 128'd0);
      check("res_valid", 128'(bus.res_valid), 128'(mq.size() > 0));
      if (mq.size() > 0)
         check("res_data", 128'({bus.res_tag, bus.res_real, bus.res_imag}), mq[0]);
      dut_acc += $countones(bus.req_valid & bus.req_ready);
      if (g >= 0) begin
         e = 128'({TAGW'(g), real_to_f32(real'(ar[g]*br[g] - ai[g]*bi[g])),
                             real_to_f32(real'(ar[g]*bi[g] + ai[g]*br[g]))});
         pend.push_back('{due: cyc + 2 + LAT, r: e});
         m_ptr = g;
      end
      if (mq.size() > 0 && rr) void'(mq.pop_front());
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drain();
      repeat (DEPTH + LAT + 8) begin
         drive('0, 100);
         tick();
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 128'(bus.req_ready), 128'd0);
      check({tag, "_valid"}, 128'(bus.res_valid), 128'd0);
      check({tag, "_res"},   128'({bus.res_tag, bus.res_real, bus.res_imag}), 128'd0);
      check({tag, "_mul"},   128'({bus.mul_areal, bus.mul_aimag, bus.mul_breal, bus.mul_bimag}), 128'd0);
   endtask

   initial begin
      int t_issue;
      int first;
      rst   = 1'b0;
      m_ptr = NREQ - 1;
      cyc   = 0;
      dut_acc = 0;
      drive('1, 100);
      #2;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Single lane 0 request with known operands: (1+2i)(3+4i) = -5+10i.
      drive(4'b0001, 100);
      ar[0] = 1; ai[0] = 2; br[0] = 3; bi[0] = 4;
      pack();
      t_issue = cyc;
      tick();
      first = -1;
      for (int k = 0; k < 40 && first < 0; k++) begin
         drive('0, 100);
         if (bus.res_valid) begin
            first = cyc;
            check("t1_re",  128'(bus.res_real), 128'(32'hC0A0_0000));
            check("t1_im",  128'(bus.res_imag), 128'(32'h4120_0000));
            check("t1_tag", 128'(bus.res_tag),  128'd0);
         end
         tick();
      end
      check("t1_latency", 128'(first - t_issue), 128'(LAT + 2));
      drain();

      // All lanes busy, consumer always ready.
      repeat (60) begin drive('1, 100); tick(); end
      drain();

      // Consumer stalled: exactly DEPTH accepts, then release.
      dut_acc = 0;
      repeat (60) begin drive('1, 0); tick(); end
      check("t3_accepts", 128'(dut_acc), 128'(DEPTH));
      repeat (80) begin drive('1, 100); tick(); end
      drain();

      // Pointer parked on lane 2, then only lanes 2 and 3 requesting.
      drive(4'b0100, 100); tick();
      repeat (20) begin drive(4'b1100, 100); tick(); end
      drain();

      // Reset with results both in flight and queued.
      repeat (8) begin drive('1, 0); tick(); end
      for (int k = 0; k < 30 && mq.size() < 3; k++) begin drive('0, 0); tick(); end
      drive('1, 0);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs("t5");
      @(posedge clk);
      #1;
      rst = 1'b1;
      pend.delete();
      mq.delete();
      m_ptr = NREQ - 1;
      cyc++;
      repeat (30) begin drive('0, 100); tick(); end
      repeat (10) begin drive('1, 100); tick(); end
      drain();

      // Random traffic with heavy and light backpressure.
      repeat (300) begin drive(NREQ'($urandom), 60); tick(); end
      repeat (200) begin drive(NREQ'($urandom), 25); tick(); end
      repeat (200) begin drive('1, 90); tick(); end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
